fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/processor_pkg.sv | 19 +
 rtl/pc_register.sv | 23 ++
 rtl/fetch_stage.sv | 86 ++++++++
 tb/tb_fetch_stage.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/processor_pkg.sv
// Shared processor constants: fetch widths, opcode field position and the bubble encoding.
package processor_pkg;

    localparam int unsigned PC_WIDTH    = 12;
    localparam int unsigned INSTR_WIDTH = 32;
    localparam int unsigned OPCODE_MSB  = 31;
    localparam int unsigned OPCODE_LSB  = 27;
    localparam int unsigned OPCODE_W    = OPCODE_MSB - OPCODE_LSB + 1;

    localparam logic [INSTR_WIDTH-1:0] NOP = '0;

    typedef logic [OPCODE_W-1:0] opcode_t;

    // Opcode field of an instruction word.
    function automatic opcode_t opcode_of(input logic [INSTR_WIDTH-1:0] instr);
        return instr[OPCODE_MSB:OPCODE_LSB];
    endfunction

endpackage

// File: rtl/pc_register.sv
// Program counter: synchronous reset, load has priority over increment.
module pc_register #(
    parameter int unsigned WIDTH = processor_pkg::PC_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] pc
);

    always_ff @(posedge clock) begin
        if (reset) begin
            pc <= '0;
        end else if (load) begin
            pc <= load_value;
        end else if (enable) begin
            pc <= pc + WIDTH'(1);
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage over a synchronous ROM, with a one-entry hold buffer so
// that a stall never costs a bubble on release.
module fetch_stage #(
    parameter int unsigned PC_WIDTH    = processor_pkg::PC_WIDTH,
    parameter int unsigned INSTR_WIDTH = processor_pkg::INSTR_WIDTH
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   stall,
    input  logic                   redirect,
    input  logic [PC_WIDTH-1:0]    redirect_pc,
    output logic [PC_WIDTH-1:0]    imem_addr,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    output logic                   if_valid,
    output logic [INSTR_WIDTH-1:0] if_instr,
    output logic [PC_WIDTH-1:0]    if_pc,
    output logic [PC_WIDTH-1:0]    if_pc_plus1,
    output logic [4:0]             if_opcode
);

    logic [PC_WIDTH-1:0]    pc;
    logic                   req_valid;
    logic [PC_WIDTH-1:0]    req_pc;
    logic                   hold_valid;
    logic [INSTR_WIDTH-1:0] hold_instr;
    logic [PC_WIDTH-1:0]    hold_pc;

    // Redirect loads regardless of stall; stall freezes the counter otherwise.
    pc_register #(
        .WIDTH (PC_WIDTH)
    ) u_pc_register (
        .clock      (clock),
        .reset      (reset),
        .enable     (!stall),
        .load       (redirect),
        .load_value (redirect_pc),
        .pc         (pc)
    );

    assign imem_addr = pc;

    // Request tracking and hold buffer; priority reset > redirect > stall > normal.
    always_ff @(posedge clock) begin
        if (reset) begin
            req_valid  <= 1'b0;
            req_pc     <= '0;
            hold_valid <= 1'b0;
            hold_instr <= '0;
            hold_pc    <= '0;
        end else if (redirect) begin
            req_valid  <= 1'b0;
            hold_valid <= 1'b0;
        end else if (stall) begin
            req_valid <= 1'b0;
            if (!hold_valid && req_valid) begin
                hold_valid <= 1'b1;
                hold_instr <= imem_rdata;
                hold_pc    <= req_pc;
            end
        end else begin
            hold_valid <= 1'b0;
            req_valid  <= 1'b1;
            req_pc     <= pc;
        end
    end

    // Presentation mux: held word wins, a bubble presents an all-zero nop.
    always_comb begin
        if_valid    = hold_valid | req_valid;
        if_instr    = INSTR_WIDTH'(processor_pkg::NOP);
        if_pc       = '0;
        if_pc_plus1 = '0;
        if (hold_valid) begin
            if_instr = hold_instr;
            if_pc    = hold_pc;
        end else if (req_valid) begin
            if_instr = imem_rdata;
            if_pc    = req_pc;
        end
        if (if_valid) begin
            if_pc_plus1 = if_pc + PC_WIDTH'(1);
        end
        if_opcode = if_instr[processor_pkg::OPCODE_MSB:processor_pkg::OPCODE_LSB];
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: directed scenarios followed by random stall/redirect/reset traffic.
module tb_fetch_stage;

    localparam int unsigned PW = 12;
    localparam int unsigned IW = 32;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          stall = 1'b0;
    logic          redirect = 1'b0;
    logic [PW-1:0] redirect_pc = '0;
    logic [PW-1:0] imem_addr;
    logic [IW-1:0] imem_rdata = '0;
    logic          if_valid;
    logic [IW-1:0] if_instr;
    logic [PW-1:0] if_pc;
    logic [PW-1:0] if_pc_plus1;
    logic [4:0]    if_opcode;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic          valid;
        logic [PW-1:0] pc;
        logic [IW-1:0] instr;
        logic [PW-1:0] pc_plus1;
        logic [4:0]    opcode;
        logic [PW-1:0] addr;
    } exp_t;

    exp_t exp_q[$];
    bit   started = 0;

    fetch_stage dut (
        .clock       (clock),
        .reset       (reset),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .if_valid    (if_valid),
        .if_instr    (if_instr),
        .if_pc       (if_pc),
        .if_pc_plus1 (if_pc_plus1),
        .if_opcode   (if_opcode)
    );

    always #5 clock = ~clock;

    function automatic logic [IW-1:0] rom_word(input logic [PW-1:0] a);
        return 32'h0800_0000 + IW'(a);
    endfunction

    // Synchronous ROM: word at the address presented one cycle earlier.
    always @(posedge clock) imem_rdata <= rom_word(imem_addr);

    // Reference model of the instruction stream the consumer sees.
    logic          m_valid = 1'b0;
    logic [PW-1:0] m_pc = '0;
    logic [PW-1:0] m_pend = '0;

    task automatic model_edge(input logic r, input logic s, input logic d, input logic [PW-1:0] t);
        if (r) begin
            m_valid = 1'b0;
            m_pend  = '0;
        end else if (d) begin
            m_valid = 1'b0;
            m_pend  = t;
        end else if (!s) begin
            if (m_valid) begin
                m_pc = PW'((int'(m_pc) + 1) % 4096);
            end else begin
                m_valid = 1'b1;
                m_pc    = m_pend;
            end
        end
    endtask

    function automatic exp_t expected_now();
        exp_t e;
        e.valid    = m_valid;
        e.pc       = m_valid ? m_pc : '0;
        e.instr    = m_valid ? rom_word(m_pc) : '0;
        e.pc_plus1 = m_valid ? PW'((int'(m_pc) + 1) % 4096) : '0;
        e.opcode   = m_valid ? 5'(e.instr >> 27) : 5'd0;
        e.addr     = m_valid ? PW'((int'(m_pc) + 1) % 4096) : m_pend;
        return e;
    endfunction

    task automatic step(input logic r, input logic s, input logic d, input logic [PW-1:0] t);
        reset = r;
        stall = s;
        redirect = d;
        redirect_pc = t;
        @(posedge clock);
        model_edge(r, s, d, t);
        exp_q.push_back(expected_now());
        started = 1;
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, req);
        end
    endtask

    // Monitor: pops one expectation per cycle and compares on the falling edge.
    initial begin
        forever begin
            @(negedge clock);
            if (started) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL scoreboard_empty at %0t: got 0 entries, expected 1", $time);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("if_valid",    32'(if_valid),    32'(e.valid));
                    check("if_pc",       32'(if_pc),       32'(e.pc));
                    check("if_instr",    if_instr,         e.instr);
                    check("if_pc_plus1", 32'(if_pc_plus1), 32'(e.pc_plus1));
                    check("if_opcode",   32'(if_opcode),   32'(e.opcode));
                    check("imem_addr",   32'(imem_addr),   32'(e.addr));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int guard;
        step(1, 0, 0, '0);
        step(1, 0, 0, '0);
        // Run from reset until word 5 is presented, then stall three edges.
        guard = 0;
        while (!(m_valid && m_pc == 12'd5) && guard < 50) begin
            step(0, 0, 0, '0);
            guard++;
        end
        repeat (3) step(0, 1, 0, '0);
        // Run to word 9, then redirect to 0x040.
        guard = 0;
        while (!(m_valid && m_pc == 12'd9) && guard < 50) begin
            step(0, 0, 0, '0);
            guard++;
        end
        step(0, 0, 1, 12'h040);
        repeat (3) step(0, 0, 0, '0);
        // Redirect together with stall while an instruction is held.
        step(0, 1, 0, '0);
        step(0, 1, 1, 12'h100);
        repeat (3) step(0, 0, 0, '0);
        // Wrap at the top of the address space.
        step(0, 0, 1, 12'hFFF);
        repeat (4) step(0, 0, 0, '0);
        // Stall during a bubble, then reset during a stall.
        step(0, 0, 1, 12'h200);
        step(0, 1, 0, '0);
        repeat (2) step(0, 0, 0, '0);
        step(0, 1, 0, '0);
        step(1, 1, 0, '0);
        repeat (4) step(0, 0, 0, '0);
        // Random traffic.
        for (int i = 0; i < 2000; i++) begin
            logic r, s, d;
            r = ($urandom_range(0, 99) == 0);
            d = ($urandom_range(0, 9) == 0);
            s = ($urandom_range(0, 3) == 0);
            step(r, s, d, PW'($urandom_range(0, 4095)));
        end
        step(0, 0, 0, '0);
        @(negedge clock);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
